// File: rtl/c_slice_logic_unit.sv
// c_slice_logic_unit: word-wide bitwise AND/OR/XOR/NAND unit that walks
// through the operands SLICE bits per clock under a start/busy/done
// handshake, then publishes zero and parity flags for the finished word.
module c_slice_logic_unit #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_last;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_op_word;
    logic [WIDTH-1:0]   w_result_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_zero;
    logic               r_parity;

    // Bitwise op over the whole latched word; each slice column only
    // ever consumes its own bits, so there is no cross-slice dependency.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [1:0]       f_op,
        input logic [WIDTH-1:0] f_x,
        input logic [WIDTH-1:0] f_y
    );
        logic [WIDTH-1:0] f_r;
        case (f_op)
            2'b00:   f_r = f_x & f_y;
            2'b01:   f_r = f_x | f_y;
            2'b10:   f_r = f_x ^ f_y;
            default: f_r = ~(f_x & f_y);
        endcase
        return f_r;
    endfunction

    assign w_op_word = apply_op(r_op, r_a, r_b);
    assign w_last    = (r_idx == IDX_W'(NSLICE - 1));

    // Merge the slice selected by the counter into the current result.
    always_comb begin
        w_result_next = r_result;
        for (int s = 0; s < NSLICE; s++) begin
            if (r_idx == IDX_W'(s)) begin
                w_result_next[s*SLICE +: SLICE] = w_op_word[s*SLICE +: SLICE];
            end
        end
    end

    // Next-state logic; a new request is taken only while not in RUN.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand latch; the run uses these copies so input changes mid-run are ignored.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a  <= a;
            r_b  <= b;
            r_op <= op;
        end
    end

    // Slice counter, result accumulation and flag update on the last slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_idx    <= '0;
            r_result <= '0;
        end else if (r_state == S_RUN) begin
            r_result <= w_result_next;
            if (w_last) begin
                r_idx    <= '0;
                r_zero   <= ~|w_result_next;
                r_parity <= ^w_result_next;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign zero   = r_zero;
    assign parity = r_parity;

endmodule

// File: tb/tb_c_slice_logic_unit.sv
// Bench for c_slice_logic_unit: three instances (16/4, 8/8, 32/4) checked
// every cycle against a transaction-level model, plus literal checks.
module tb_c_slice_logic_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st   [3];
    logic [1:0]  opv  [3];
    logic [31:0] av   [3];
    logic [31:0] bv   [3];
    logic        bz   [3];
    logic        dn   [3];
    logic        zr   [3];
    logic        pr   [3];
    logic [15:0] r0;
    logic [7:0]  r1;
    logic [31:0] r2;

    int n_vec = 0;
    int n_err = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    c_slice_logic_unit #(.WIDTH(16), .SLICE(4)) u_d0 (
        .clk(clk), .rst(rst), .start(st[0]), .op(opv[0]),
        .a(av[0][15:0]), .b(bv[0][15:0]),
        .busy(bz[0]), .done(dn[0]), .result(r0), .zero(zr[0]), .parity(pr[0]));

    c_slice_logic_unit #(.WIDTH(8), .SLICE(8)) u_d1 (
        .clk(clk), .rst(rst), .start(st[1]), .op(opv[1]),
        .a(av[1][7:0]), .b(bv[1][7:0]),
        .busy(bz[1]), .done(dn[1]), .result(r1), .zero(zr[1]), .parity(pr[1]));

    c_slice_logic_unit #(.WIDTH(32), .SLICE(4)) u_d2 (
        .clk(clk), .rst(rst), .start(st[2]), .op(opv[2]),
        .a(av[2]), .b(bv[2]),
        .busy(bz[2]), .done(dn[2]), .result(r2), .zero(zr[2]), .parity(pr[2]));

    function automatic int wof(input int i);
        return (i == 0) ? 16 : ((i == 1) ? 8 : 32);
    endfunction

    function automatic int sof(input int i);
        return (i == 1) ? 8 : 4;
    endfunction

    function automatic logic [31:0] lowmask(input int n);
        logic [31:0] m;
        m = '0;
        for (int j = 0; j < 32; j++) if (j < n) m[j] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] x,
                                           input logic [31:0] y, input int w);
        logic [31:0] r;
        case (o)
            2'b00:   r = x & y;
            2'b01:   r = x | y;
            2'b10:   r = x ^ y;
            default: r = ~(x & y);
        endcase
        return r & lowmask(w);
    endfunction

    function automatic logic [31:0] dut_res(input int i);
        if (i == 0) return {16'b0, r0};
        if (i == 1) return {24'b0, r1};
        return r2;
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_act  [3];
    int          m_k    [3];
    logic [31:0] m_full [3];
    logic [31:0] m_res  [3];
    logic        m_done [3];
    logic        m_zero [3];
    logic        m_par  [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 1'b0; m_k[i] = 0; m_full[i] = '0; m_res[i] = '0;
            m_done[i] = 1'b0; m_zero[i] = 1'b0; m_par[i] = 1'b0;
        end
    end

    task automatic model_step(input int i);
        int n;
        logic nd;
        n  = wof(i) / sof(i);
        nd = 1'b0;
        if (rst) begin
            m_act[i] = 1'b0; m_k[i] = 0; m_res[i] = '0;
            m_zero[i] = 1'b0; m_par[i] = 1'b0;
        end else if (m_act[i]) begin
            m_k[i]   = m_k[i] + 1;
            m_res[i] = m_full[i] & lowmask(m_k[i] * sof(i));
            if (m_k[i] == n) begin
                m_act[i]  = 1'b0;
                nd        = 1'b1;
                m_zero[i] = (m_full[i] == 32'd0);
                m_par[i]  = ^m_full[i];
            end
        end else if (st[i]) begin
            m_full[i] = ref_op(opv[i], av[i], bv[i], wof(i));
            m_res[i]  = '0;
            m_k[i]    = 0;
            m_act[i]  = 1'b1;
        end
        m_done[i] = nd;
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) model_step(i);
    end

    // Compare every instance against the model on each falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (bz[i] !== m_act[i] || dn[i] !== m_done[i] || dut_res(i) !== m_res[i] ||
                    zr[i] !== m_zero[i] || pr[i] !== m_par[i]) begin
                    n_err++;
                    $display("FAIL model[%0d] t=%0t got busy=%b done=%b res=%h z=%b p=%b want busy=%b done=%b res=%h z=%b p=%b",
                             i, $time, bz[i], dn[i], dut_res(i), zr[i], pr[i],
                             m_act[i], m_done[i], m_res[i], m_zero[i], m_par[i]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int i, output int lat);
        lat = 0;
        while (dn[i] !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) chk("done_timeout", 32'd0, 32'd1);
    endtask

    // Start an op on instance i; lat = edges from acceptance to done.
    task automatic run_op(input int i, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int lat);
        @(negedge clk);
        st[i] = 1'b1; opv[i] = o; av[i] = x; bv[i] = y;
        @(negedge clk);
        st[i] = 1'b0;
        wait_done(i, lat);
    endtask

    initial begin
        int lat;
        logic [31:0] x, y;
        logic [1:0]  o;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0; opv[i] = 2'b00; av[i] = '0; bv[i] = '0;
        end
        rst = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'b0, bz[0]}, 32'd0);
        chk("rst_done", {31'b0, dn[0]}, 32'd0);
        chk("rst_result", dut_res(0), 32'd0);
        chk("rst_zero", {31'b0, zr[0]}, 32'd0);
        chk("rst_parity", {31'b0, pr[0]}, 32'd0);

        // AND
        run_op(0, 2'b00, 32'hF0F0, 32'hFF00, lat);
        chk("and_latency", lat, 32'd4);
        chk("and_result", dut_res(0), 32'hF000);
        chk("and_zero", {31'b0, zr[0]}, 32'd0);
        chk("and_parity", {31'b0, pr[0]}, 32'd0);
        @(negedge clk);
        chk("and_done_pulse", {31'b0, dn[0]}, 32'd0);

        // OR with mid-run probing
        @(negedge clk);
        st[0] = 1'b1; opv[0] = 2'b01; av[0] = 32'h0F0F; bv[0] = 32'hF000;
        @(negedge clk);
        st[0] = 1'b0;
        chk("or_e0", dut_res(0), 32'h0000);
        @(negedge clk); chk("or_e1", dut_res(0), 32'h000F);
        @(negedge clk); chk("or_e2", dut_res(0), 32'h000F);
        @(negedge clk); chk("or_e3", dut_res(0), 32'h0F0F);
        @(negedge clk); chk("or_e4", dut_res(0), 32'hFF0F);
        chk("or_done", {31'b0, dn[0]}, 32'd1);
        chk("or_parity", {31'b0, pr[0]}, 32'd0);

        // XOR with operand change mid-run
        @(negedge clk);
        st[0] = 1'b1; opv[0] = 2'b10; av[0] = 32'h1234; bv[0] = 32'h1234;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        av[0] = 32'hFFFF;
        wait_done(0, lat);
        chk("xor_result", dut_res(0), 32'h0000);
        chk("xor_zero", {31'b0, zr[0]}, 32'd1);
        chk("xor_parity", {31'b0, pr[0]}, 32'd0);

        // NAND with a second start during RUN
        @(negedge clk);
        st[0] = 1'b1; opv[0] = 2'b11; av[0] = 32'hFFFF; bv[0] = 32'h0001;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        st[0] = 1'b1; opv[0] = 2'b00; av[0] = 32'h0; bv[0] = 32'h0;
        @(negedge clk);
        st[0] = 1'b0;
        wait_done(0, lat);
        chk("nand_result", dut_res(0), 32'hFFFE);
        chk("nand_parity", {31'b0, pr[0]}, 32'd1);
        chk("nand_zero", {31'b0, zr[0]}, 32'd0);
        @(negedge clk);
        chk("nand_no_rerun", {31'b0, bz[0]}, 32'd0);

        // Reset abort on the second RUN cycle
        @(negedge clk);
        st[0] = 1'b1; opv[0] = 2'b10; av[0] = 32'hAAAA; bv[0] = 32'h5555;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'b0, bz[0]}, 32'd0);
        chk("abort_done", {31'b0, dn[0]}, 32'd0);
        chk("abort_result", dut_res(0), 32'd0);
        chk("abort_zero", {31'b0, zr[0]}, 32'd0);
        chk("abort_parity", {31'b0, pr[0]}, 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, dn[0]}, 32'd0);
        end

        // Back-to-back with start held through DONE
        @(negedge clk);
        st[0] = 1'b1; opv[0] = 2'b00; av[0] = 32'hFFFF; bv[0] = 32'h00FF;
        @(negedge clk);
        wait_done(0, lat);
        chk("b2b_first", dut_res(0), 32'h00FF);
        opv[0] = 2'b01; av[0] = 32'h1234; bv[0] = 32'hFFFF;
        @(negedge clk);
        st[0] = 1'b0;
        chk("b2b_no_idle", {31'b0, bz[0]}, 32'd1);
        wait_done(0, lat);
        chk("b2b_latency", lat, 32'd4);
        chk("b2b_second", dut_res(0), 32'hFFFF);

        // Parameter sweep on the 8/8 and 32/4 instances
        for (int i = 1; i < 3; i++) begin
            for (int it = 0; it < 8; it++) begin
                o = 2'(it % 4);
                x = $urandom;
                y = $urandom;
                run_op(i, o, x & lowmask(wof(i)), y & lowmask(wof(i)), lat);
                chk("sweep_latency", lat, wof(i) / sof(i));
                chk("sweep_result", dut_res(i), ref_op(o, x, y, wof(i)));
                chk("sweep_parity", {31'b0, pr[i]}, {31'b0, ^ref_op(o, x, y, wof(i))});
            end
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
